mul_seq: RTL



---
 rtl/mul_seq_pkg.sv | 28 ++
 rtl/mul_seq_if.sv | 29 ++
 rtl/adder.sv | 18 +
 rtl/mul_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared constants and types for the iterative RV32M multiplier.
//   XLEN       operand/result width (only 32 is supported)
//   MUL_ITERS  number of shift-add iterations in CALC
//   mul_op_e   request opcode encoding
//   mul_state_e sequencer state encoding
package mul_seq_pkg;

  localparam int XLEN      = 32;
  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,  // low word, sign-agnostic
    OP_MULH   = 2'b01,  // signed x signed, high word
    OP_MULHSU = 2'b10,  // signed x unsigned, high word
    OP_MULHU  = 2'b11   // unsigned x unsigned, high word
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_CALC   = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5,
    ST_DONE   = 3'd6
  } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response bundle between the execute stage and mul_seq.
//   req_valid/req_ready    request handshake
//   req_op, req_a, req_b   opcode and operands (rs1, rs2)
//   resp_valid/resp_ready  response handshake
//   resp_result            selected product word
// master = core side, slave = multiplier side.
interface mul_seq_if;
  import mul_seq_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );

endinterface

// File: rtl/adder.sv
// adder: plain WIDTH-bit ripple/synthesised adder with carry in and out.
//   a, b  addends
//   cin   carry in
//   sum   a + b + cin (low WIDTH bits)
//   cout  carry out of the top bit
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mul_seq.sv
// mul_seq: iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around a
// single shared adder. Operands are converted to magnitudes, multiplied by a
// 32-step shift-add loop, and the 64-bit product is negated back if needed.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       synchronous abort; in-flight op is dropped without response
//   bus         mul_seq_if.slave request/response handshake
// Optional build macro MUL_SEQ_EARLY_EXIT_EN: leave CALC as soon as the
// remaining multiplier bits are zero and finish the shifts with one barrel
// shift (variable latency, identical results).
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  mul_seq_if.slave   bus
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] NEG_A  = ST_NEG_A;
  localparam logic [2:0] NEG_B  = ST_NEG_B;
  localparam logic [2:0] CALC   = ST_CALC;
  localparam logic [2:0] FIX_LO = ST_FIX_LO;
  localparam logic [2:0] FIX_HI = ST_FIX_HI;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0]      state_r, state_next_s;
  logic [1:0]      op_r;
  logic            neg_a_r, neg_b_r, neg_p_r, c_r;
  logic [XLEN-1:0] mcand_r, hi_r, lo_r;
  logic [4:0]      cnt_r;
  logic            req_ready_r, resp_valid_r;
  logic [XLEN-1:0] resp_result_r;
  logic            accept_s, early_s;
  logic [XLEN-1:0] add_a_s, add_b_s, add_sum_s;
  logic            add_cin_s, add_cout_s;

`ifdef MUL_SEQ_EARLY_EXIT_EN
  // Multiplier bits not yet consumed by the shift-add loop.
  logic [XLEN-1:0] mrem_r;
  logic [5:0]      shamt_s;
  assign early_s = (mrem_r == 32'd0);
  assign shamt_s = 6'(MUL_ITERS) - {1'b0, cnt_r};
`else
  assign early_s = 1'b0;
`endif

  assign accept_s        = bus.req_valid && req_ready_r;
  assign bus.req_ready   = req_ready_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.resp_result = resp_result_r;

  adder #(.WIDTH(XLEN)) u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Adder operand mux: conditional two's complement is (x ^ mask) + neg.
  always_comb begin
    add_a_s   = 32'd0;
    add_b_s   = 32'd0;
    add_cin_s = 1'b0;
    case (state_r)
      NEG_A: begin
        add_a_s   = mcand_r ^ {XLEN{neg_a_r}};
        add_cin_s = neg_a_r;
      end
      NEG_B: begin
        add_a_s   = lo_r ^ {XLEN{neg_b_r}};
        add_cin_s = neg_b_r;
      end
      CALC: begin
        add_a_s = hi_r;
        add_b_s = lo_r[0] ? mcand_r : 32'd0;
      end
      FIX_LO: begin
        add_a_s   = lo_r ^ {XLEN{neg_p_r}};
        add_cin_s = neg_p_r;
      end
      FIX_HI: begin
        // Carry out of the low-word negation only propagates when lo was 0.
        add_a_s   = hi_r ^ {XLEN{neg_p_r}};
        add_cin_s = c_r;
      end
      default: begin
        add_a_s   = 32'd0;
        add_b_s   = 32'd0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:   state_next_s = accept_s ? NEG_A : IDLE;
        NEG_A:  state_next_s = NEG_B;
        NEG_B:  state_next_s = CALC;
        CALC:   state_next_s = ((cnt_r == 5'(MUL_ITERS - 1)) || early_s) ? FIX_LO : CALC;
        FIX_LO: state_next_s = FIX_HI;
        FIX_HI: state_next_s = DONE;
        DONE:   state_next_s = bus.resp_ready ? IDLE : DONE;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // State, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      op_r          <= 2'd0;
      neg_a_r       <= 1'b0;
      neg_b_r       <= 1'b0;
      neg_p_r       <= 1'b0;
      c_r           <= 1'b0;
      mcand_r       <= 32'd0;
      hi_r          <= 32'd0;
      lo_r          <= 32'd0;
      cnt_r         <= 5'd0;
      req_ready_r   <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_result_r <= 32'd0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      mrem_r        <= 32'd0;
`endif
    end else begin
      req_ready_r <= (state_next_s == IDLE);
      state_r     <= state_next_s;
      if (flush) begin
        resp_valid_r <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              // a is signed for every op except MULHU; b only for MUL/MULH.
              op_r    <= bus.req_op;
              mcand_r <= bus.req_a;
              lo_r    <= bus.req_b;
              hi_r    <= 32'd0;
              cnt_r   <= 5'd0;
              neg_a_r <= bus.req_a[31] & (bus.req_op != OP_MULHU);
              neg_b_r <= bus.req_b[31] & (bus.req_op[1] == 1'b0);
              neg_p_r <= (bus.req_a[31] & (bus.req_op != OP_MULHU)) ^
                         (bus.req_b[31] & (bus.req_op[1] == 1'b0));
            end
          end
          NEG_A: mcand_r <= add_sum_s;
          NEG_B: begin
            lo_r <= add_sum_s;
            hi_r <= 32'd0;
`ifdef MUL_SEQ_EARLY_EXIT_EN
            mrem_r <= add_sum_s;
`endif
          end
          CALC: begin
`ifdef MUL_SEQ_EARLY_EXIT_EN
            if (early_s) begin
              {hi_r, lo_r} <= {hi_r, lo_r} >> shamt_s;
            end else begin
              hi_r   <= {add_cout_s, add_sum_s[31:1]};
              lo_r   <= {add_sum_s[0], lo_r[31:1]};
              mrem_r <= mrem_r >> 1;
            end
`else
            hi_r <= {add_cout_s, add_sum_s[31:1]};
            lo_r <= {add_sum_s[0], lo_r[31:1]};
`endif
            cnt_r <= cnt_r + 5'd1;
          end
          FIX_LO: begin
            lo_r <= add_sum_s;
            c_r  <= add_cout_s;
          end
          FIX_HI: begin
            hi_r          <= add_sum_s;
            resp_valid_r  <= 1'b1;
            resp_result_r <= (op_r == OP_MUL) ? lo_r : add_sum_s;
          end
          DONE: begin
            if (bus.resp_ready) begin
              resp_valid_r <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
